// File: rtl/amux_sel_arbiter_pkg.sv
// amux_ctrl_pkg: shared types, constants and helpers for the analog output
// mux select arbiter (amux_sel_arbiter) and its timer sub-module.
//   amux_state_e : controller states IDLE / SETTLE / OWN (2-bit encoding)
//   REQ_SPI/RST  : requester indices (0 = SPI SDO readback, 1 = reset/status)
//   cnt_width()  : width for the settle/hold timers, clog2(max(a,b)+1)
//   grant_vec()  : one-hot grant vector for a requester index
package amux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OWN    = 2'd2
    } amux_state_e;

    localparam logic REQ_SPI = 1'b0;
    localparam logic REQ_RST = 1'b1;

    function automatic int cnt_width(input int settle_cycles, input int min_hold);
        int m;
        m = (settle_cycles > min_hold) ? settle_cycles : min_hold;
        return $clog2(m + 1);
    endfunction

    function automatic logic [1:0] grant_vec(input logic idx);
        return (idx == REQ_RST) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/amux_sel_arbiter_if.sv
// amux_sel_arbiter_if: request/grant and mux-status bundle between the two
// analog-output requesters and the select arbiter.
//   req        : level requests, bit i high while requester i needs the output
//   gnt        : one-hot-or-zero grant
//   select     : mux select (0 = I0/SPI, 1 = I1/reset-status)
//   sel_stable : low while the mux is settling after a select change
//   busy       : arbiter not idle
//   sw_cnt     : wrapping count of select changes
// modport master = requester side, modport slave = arbiter side.
interface amux_sel_arbiter_if #(
    parameter int SW_CNT_W = 8
);
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                select;
    logic                sel_stable;
    logic                busy;
    logic [SW_CNT_W-1:0] sw_cnt;

    modport master (
        output req,
        input  gnt, select, sel_stable, busy, sw_cnt
    );

    modport slave (
        input  req,
        output gnt, select, sel_stable, busy, sw_cnt
    );
endinterface

// File: rtl/amux_sel_arbiter_hold_timer.sv
// amux_hold_timer: loadable saturating up-counter.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   clr       : force count to 0 (highest priority after reset)
//   load      : load load_val (clamped to MAX_VAL)
//   en        : count up by one, stopping at MAX_VAL
//   sat       : count == MAX_VAL
module amux_hold_timer #(
    parameter int WIDTH   = 5,
    parameter int MAX_VAL = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             sat
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (load_val > MAX_W) ? MAX_W : load_val;
        end else if (en && (cnt_q != MAX_W)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == MAX_W);

endmodule

// File: rtl/amux_sel_arbiter.sv
// amux_sel_arbiter: owns the select line of the 2:1 analog output mux and
// shares the output between requester 0 (SPI SDO readback) and requester 1
// (reset/status monitor). Break-before-make switching, a settle delay after
// every select change, and round-robin on simultaneous requests.
//   CLK  : system clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : amux_sel_arbiter_if.slave (req in; gnt/select/sel_stable/busy/sw_cnt out)
// Optional feature macro: AMUX_PREEMPT_EN -- when defined, an owner that has
// held the grant for MIN_HOLD cycles is released if the other side requests.
//
// state  | meaning
// IDLE   | no grant; picks a target and either grants or moves select
// SETTLE | select just changed, waiting SETTLE_CYCLES before granting
// OWN    | gnt[select] high until the owner drops req (or is pre-empted)
import amux_ctrl_pkg::*;

module amux_sel_arbiter #(
    parameter int SETTLE_CYCLES = 4,
    parameter int MIN_HOLD      = 16,
    parameter int SW_CNT_W      = 8
) (
    input  logic CLK,
    input  logic RST,
    amux_sel_arbiter_if.slave bus
);
    localparam int CNT_W = cnt_width(SETTLE_CYCLES, MIN_HOLD);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETTLE = SETTLE;
    localparam logic [1:0] S_OWN    = OWN;

    logic [1:0]          state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                select_q, select_d;
    logic                sel_stable_q, sel_stable_d;
    logic                busy_q, busy_d;
    logic [SW_CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic                last_owner_q, last_owner_d;

    logic target;
    logic other;
    logic release_own;
    logic settle_clr;
    logic settle_en;
    logic settle_done;

    // Lone requester wins outright; on a tie the side that did not own last.
    always_comb begin
        target = (bus.req == 2'b11) ? ~last_owner_q : bus.req[REQ_RST];
    end

    assign other = ~select_q;

    amux_hold_timer #(
        .WIDTH   (CNT_W),
        .MAX_VAL (SETTLE_CYCLES - 1)
    ) u_settle_timer (
        .clk      (CLK),
        .rst      (RST),
        .clr      (settle_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (settle_en),
        .sat      (settle_done)
    );

`ifdef AMUX_PREEMPT_EN
    logic hold_clr;
    logic hold_en;
    logic hold_sat;

    amux_hold_timer #(
        .WIDTH   (CNT_W),
        .MAX_VAL (MIN_HOLD)
    ) u_hold_timer (
        .clk      (CLK),
        .rst      (RST),
        .clr      (hold_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (hold_en),
        .sat      (hold_sat)
    );

    assign hold_clr    = (state_d == S_OWN) && (state_q != S_OWN);
    assign hold_en     = (state_q == S_OWN);
    assign release_own = !bus.req[select_q] || (bus.req[other] && hold_sat);
`else
    assign release_own = !bus.req[select_q];
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        select_d     = select_q;
        sel_stable_d = sel_stable_q;
        sw_cnt_d     = sw_cnt_q;
        last_owner_d = last_owner_q;
        settle_clr   = 1'b0;
        settle_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                gnt_d        = 2'b00;
                sel_stable_d = 1'b1;
                if (bus.req != 2'b00) begin
                    if (target == select_q) begin
                        state_d = S_OWN;
                        gnt_d   = grant_vec(target);
                    end else begin
                        // gnt is already low here, so moving select is safe.
                        state_d      = S_SETTLE;
                        select_d     = target;
                        sw_cnt_d     = sw_cnt_q + 1'b1;
                        sel_stable_d = 1'b0;
                        settle_clr   = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                settle_en = 1'b1;
                if (!bus.req[select_q]) begin
                    state_d      = S_IDLE;
                    sel_stable_d = 1'b1;
                end else if (settle_done) begin
                    state_d      = S_OWN;
                    gnt_d        = grant_vec(select_q);
                    sel_stable_d = 1'b1;
                end
            end
            S_OWN: begin
                // Release only drops gnt; select can move no earlier than the
                // following IDLE edge.
                if (release_own) begin
                    state_d      = S_IDLE;
                    gnt_d        = 2'b00;
                    last_owner_d = select_q;
                end
            end
            default: begin
                state_d      = S_IDLE;
                gnt_d        = 2'b00;
                sel_stable_d = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'b00;
            select_q     <= REQ_SPI;
            sel_stable_q <= 1'b1;
            busy_q       <= 1'b0;
            sw_cnt_q     <= '0;
            last_owner_q <= REQ_RST;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            select_q     <= select_d;
            sel_stable_q <= sel_stable_d;
            busy_q       <= busy_d;
            sw_cnt_q     <= sw_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.select     = select_q;
    assign bus.sel_stable = sel_stable_q;
    assign bus.busy       = busy_q;
    assign bus.sw_cnt     = sw_cnt_q;

endmodule
